// File: rtl/core_iencode.sv
// RV32I instruction encoder: packs field bundles into 32-bit words, checks immediates,
// and streams words with sequential word-aligned addresses through a small FIFO.
module core_iencode #(
    parameter logic [31:0] START_ADDR = 32'h0000_0000,
    parameter int          DEPTH      = 2
) (
    input  logic        CLK,
    input  logic        NRST,
    input  logic        IN_VALID,
    output logic        IN_READY,
    input  logic [6:0]  IN_OPCODE,
    input  logic [4:0]  IN_RD,
    input  logic [4:0]  IN_RS1,
    input  logic [4:0]  IN_RS2,
    input  logic [2:0]  IN_FUNCT3,
    input  logic [6:0]  IN_FUNCT7,
    input  logic [31:0] IN_IMM,
    output logic        OUT_VALID,
    input  logic        OUT_READY,
    output logic [31:0] OUT_INSTR,
    output logic [31:0] OUT_ADDR,
    output logic        ERR,
    output logic [1:0]  ERR_CODE,
    output logic [7:0]  DROP_CNT,
    input  logic        CLR_ERR
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [DEPTH-1:0][31:0] instr_q, instr_d;
    logic [DEPTH-1:0][31:0] addr_q, addr_d;
    logic [PW-1:0]          wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]          count_q, count_d;
    logic [31:0]            pc_q, pc_d;
    logic                   in_ready_q, in_ready_d;
    logic                   err_q, err_d;
    logic [1:0]             err_code_q, err_code_d;
    logic [7:0]             drop_cnt_q, drop_cnt_d;

    logic [31:0] enc;
    logic        bad_op, misal, range_err;
    logic        ok11, ok12, ok20;
    logic        accept, drop, push, pop;
    logic [1:0]  new_code;

    assign ok11 = (&IN_IMM[31:11]) | ~(|IN_IMM[31:11]);
    assign ok12 = (&IN_IMM[31:12]) | ~(|IN_IMM[31:12]);
    assign ok20 = (&IN_IMM[31:20]) | ~(|IN_IMM[31:20]);

    always_comb begin
        enc       = '0;
        bad_op    = 1'b0;
        misal     = 1'b0;
        range_err = 1'b0;
        case (IN_OPCODE)
            7'b0110011: enc = {IN_FUNCT7, IN_RS2, IN_RS1, IN_FUNCT3, IN_RD, IN_OPCODE};
            7'b0010011: begin
                // Shift-immediates carry funct7 in the upper bits and a 5-bit shamt.
                if (IN_FUNCT3 == 3'b001 || IN_FUNCT3 == 3'b101) begin
                    enc       = {IN_FUNCT7, IN_IMM[4:0], IN_RS1, IN_FUNCT3, IN_RD, IN_OPCODE};
                    range_err = |IN_IMM[31:5];
                end else begin
                    enc       = {IN_IMM[11:0], IN_RS1, IN_FUNCT3, IN_RD, IN_OPCODE};
                    range_err = ~ok11;
                end
            end
            7'b0000011, 7'b1100111: begin
                enc       = {IN_IMM[11:0], IN_RS1, IN_FUNCT3, IN_RD, IN_OPCODE};
                range_err = ~ok11;
            end
            7'b0100011: begin
                enc       = {IN_IMM[11:5], IN_RS2, IN_RS1, IN_FUNCT3, IN_IMM[4:0], IN_OPCODE};
                range_err = ~ok11;
            end
            7'b1100011: begin
                enc       = {IN_IMM[12], IN_IMM[10:5], IN_RS2, IN_RS1, IN_FUNCT3,
                             IN_IMM[4:1], IN_IMM[11], IN_OPCODE};
                misal     = IN_IMM[0];
                range_err = ~ok12;
            end
            7'b0110111, 7'b0010111: begin
                enc       = {IN_IMM[31:12], IN_RD, IN_OPCODE};
                range_err = |IN_IMM[11:0];
            end
            7'b1101111: begin
                enc       = {IN_IMM[20], IN_IMM[10:1], IN_IMM[11], IN_IMM[19:12], IN_RD, IN_OPCODE};
                misal     = IN_IMM[0];
                range_err = ~ok20;
            end
            default: bad_op = 1'b1;
        endcase
    end

    assign new_code = bad_op ? 2'b01 : (misal ? 2'b11 : 2'b10);
    assign accept   = IN_VALID & in_ready_q;
    assign drop     = accept & (bad_op | misal | range_err);
    assign push     = accept & ~drop;
    assign pop      = OUT_VALID & OUT_READY;

    always_comb begin
        instr_d  = instr_q;
        addr_d   = addr_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        pc_d     = pc_q;
        if (push) begin
            instr_d[wr_ptr_q] = enc;
            addr_d[wr_ptr_q]  = pc_q;
            wr_ptr_d          = wr_ptr_q + PW'(1);
            pc_d              = pc_q + 32'd4;
        end
        if (pop) rd_ptr_d = rd_ptr_q + PW'(1);
        count_d    = count_q + CW'(push) - CW'(pop);
        // Readiness follows the post-edge occupancy, so a pop frees space one cycle later.
        in_ready_d = (count_d < DEPTH_C);
    end

    always_comb begin
        err_d      = err_q;
        err_code_d = err_code_q;
        drop_cnt_d = drop_cnt_q;
        if (CLR_ERR) begin
            err_d      = 1'b0;
            err_code_d = 2'b00;
            drop_cnt_d = 8'd0;
        end
        // Applied after the clear so a coincident new error survives it.
        if (drop) begin
            if (!err_d) err_code_d = new_code;
            err_d = 1'b1;
            if (drop_cnt_d != 8'hFF) drop_cnt_d = drop_cnt_d + 8'd1;
        end
    end

    always_ff @(posedge CLK or negedge NRST) begin
        if (!NRST) begin
            instr_q    <= '0;
            addr_q     <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            pc_q       <= {START_ADDR[31:2], 2'b00};
            in_ready_q <= 1'b0;
            err_q      <= 1'b0;
            err_code_q <= 2'b00;
            drop_cnt_q <= 8'd0;
        end else begin
            instr_q    <= instr_d;
            addr_q     <= addr_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            pc_q       <= pc_d;
            in_ready_q <= in_ready_d;
            err_q      <= err_d;
            err_code_q <= err_code_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign IN_READY  = in_ready_q;
    assign OUT_VALID = (count_q != '0);
    assign OUT_INSTR = OUT_VALID ? instr_q[rd_ptr_q] : 32'd0;
    assign OUT_ADDR  = OUT_VALID ? addr_q[rd_ptr_q] : 32'd0;
    assign ERR       = err_q;
    assign ERR_CODE  = err_code_q;
    assign DROP_CNT  = drop_cnt_q;
endmodule

// File: tb/tb_core_iencode.sv
// Directed bench for core_iencode: encodings, immediate checks, backpressure, reset.
module tb_core_iencode;
    localparam logic [31:0] START = 32'h0000_1000;

    logic        CLK = 1'b0, NRST = 1'b0;
    logic        IN_VALID = 1'b0, IN_READY;
    logic [6:0]  IN_OPCODE = '0, IN_FUNCT7 = '0;
    logic [4:0]  IN_RD = '0, IN_RS1 = '0, IN_RS2 = '0;
    logic [2:0]  IN_FUNCT3 = '0;
    logic [31:0] IN_IMM = '0;
    logic        OUT_VALID, OUT_READY = 1'b1;
    logic [31:0] OUT_INSTR, OUT_ADDR;
    logic        ERR, CLR_ERR = 1'b0;
    logic [1:0]  ERR_CODE;
    logic [7:0]  DROP_CNT;

    int          checks = 0, errors = 0;
    logic [31:0] exp_addr;

    core_iencode #(.START_ADDR(START), .DEPTH(2)) dut (
        .CLK(CLK), .NRST(NRST), .IN_VALID(IN_VALID), .IN_READY(IN_READY),
        .IN_OPCODE(IN_OPCODE), .IN_RD(IN_RD), .IN_RS1(IN_RS1), .IN_RS2(IN_RS2),
        .IN_FUNCT3(IN_FUNCT3), .IN_FUNCT7(IN_FUNCT7), .IN_IMM(IN_IMM),
        .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY), .OUT_INSTR(OUT_INSTR),
        .OUT_ADDR(OUT_ADDR), .ERR(ERR), .ERR_CODE(ERR_CODE), .DROP_CNT(DROP_CNT),
        .CLR_ERR(CLR_ERR)
    );

    always #5 CLK = ~CLK;

    // Presents one bundle from a falling edge and holds it until a rising edge accepts it.
    task automatic push(input logic [6:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                        input logic [4:0] rs2, input logic [2:0] f3, input logic [6:0] f7,
                        input logic [31:0] imm, output bit ok);
        @(negedge CLK);
        IN_OPCODE = op; IN_RD = rd; IN_RS1 = rs1; IN_RS2 = rs2;
        IN_FUNCT3 = f3; IN_FUNCT7 = f7; IN_IMM = imm; IN_VALID = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (IN_READY) begin ok = 1'b1; break; end
            @(negedge CLK);
        end
        if (ok) @(posedge CLK);
        #1 IN_VALID = 1'b0;
    endtask

    task automatic test_reset();
        #3;
        checks++; if (IN_READY !== 1'b0 || OUT_VALID !== 1'b0) begin errors++;
            $display("FAIL reset_hs: in_ready=%b out_valid=%b exp 0 0", IN_READY, OUT_VALID); end
        checks++; if (OUT_INSTR !== 32'd0 || OUT_ADDR !== 32'd0) begin errors++;
            $display("FAIL reset_out: instr=%h addr=%h exp 0 0", OUT_INSTR, OUT_ADDR); end
        checks++; if (ERR !== 1'b0 || ERR_CODE !== 2'b00 || DROP_CNT !== 8'd0) begin errors++;
            $display("FAIL reset_err: err=%b code=%b drop=%0d exp 0 00 0", ERR, ERR_CODE, DROP_CNT); end
        @(negedge CLK); NRST = 1'b1;
        @(negedge CLK);
        checks++; if (IN_READY !== 1'b1) begin errors++;
            $display("FAIL ready_after_reset: got %b exp 1", IN_READY); end
        exp_addr = START;
    endtask

    task automatic test_first_word();
        bit ok;
        push(7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5, ok);
        @(negedge CLK);
        checks++; if (!ok || OUT_VALID !== 1'b1 || OUT_INSTR !== 32'h00500093) begin errors++;
            $display("FAIL addi_first: ok=%b valid=%b instr=%h exp 1 1 00500093", ok, OUT_VALID, OUT_INSTR); end
        checks++; if (OUT_ADDR !== START) begin errors++;
            $display("FAIL addi_first_addr: got %h exp %h", OUT_ADDR, START); end
        exp_addr = START + 32'd4;
    endtask

    task automatic test_encodings();
        logic [6:0]  op [9] = '{7'h33, 7'h23, 7'h63, 7'h6F, 7'h37, 7'h13, 7'h13, 7'h13, 7'h03};
        logic [4:0]  rd [9] = '{5'd3, 5'd0, 5'd0, 5'd1, 5'd5, 5'd1, 5'd1, 5'd2, 5'd4};
        logic [4:0]  r1 [9] = '{5'd1, 5'd1, 5'd1, 5'd0, 5'd0, 5'd0, 5'd0, 5'd3, 5'd2};
        logic [4:0]  r2 [9] = '{5'd2, 5'd2, 5'd2, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0};
        logic [2:0]  f3 [9] = '{3'd0, 3'd2, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd5, 3'd2};
        logic [6:0]  f7 [9] = '{7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h20, 7'h00};
        logic [31:0] im [9] = '{32'd0, 32'd8, 32'hFFFF_FFF8, 32'd8, 32'h1234_5000,
                                32'hFFFF_F800, 32'h0000_07FF, 32'd4, 32'hFFFF_FFFC};
        logic [31:0] ex [9] = '{32'h002081B3, 32'h0020A423, 32'hFE208CE3, 32'h008000EF,
                                32'h123452B7, 32'h80000093, 32'h7FF00093, 32'h4041D113,
                                32'hFFC12203};
        bit ok;
        for (int i = 0; i < 9; i++) begin
            push(op[i], rd[i], r1[i], r2[i], f3[i], f7[i], im[i], ok);
            @(negedge CLK);
            checks++; if (!ok || OUT_VALID !== 1'b1 || OUT_INSTR !== ex[i] || OUT_ADDR !== exp_addr) begin
                errors++;
                $display("FAIL enc_%0d: ok=%b valid=%b instr=%h addr=%h exp instr=%h addr=%h",
                         i, ok, OUT_VALID, OUT_INSTR, OUT_ADDR, ex[i], exp_addr);
            end
            exp_addr = exp_addr + 32'd4;
        end
        checks++; if (ERR !== 1'b0) begin errors++;
            $display("FAIL enc_no_err: err=%b exp 0", ERR); end
    endtask

    task automatic test_errors();
        bit ok;
        push(7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048, ok);
        @(negedge CLK);
        checks++; if (OUT_VALID !== 1'b0 || ERR !== 1'b1 || ERR_CODE !== 2'b10 || DROP_CNT !== 8'd1) begin
            errors++;
            $display("FAIL range_drop: valid=%b err=%b code=%b drop=%0d exp 0 1 10 1",
                     OUT_VALID, ERR, ERR_CODE, DROP_CNT);
        end
        push(7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5, ok);
        @(negedge CLK);
        checks++; if (OUT_VALID !== 1'b1 || OUT_INSTR !== 32'h00500093 || OUT_ADDR !== exp_addr) begin
            errors++;
            $display("FAIL addr_after_drop: instr=%h addr=%h exp 00500093 %h", OUT_INSTR, OUT_ADDR, exp_addr);
        end
        exp_addr = exp_addr + 32'd4;
        push(7'b1100011, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'd3, ok);
        @(negedge CLK);
        checks++; if (ERR_CODE !== 2'b10 || DROP_CNT !== 8'd2 || OUT_VALID !== 1'b0) begin errors++;
            $display("FAIL sticky_code: code=%b drop=%0d valid=%b exp 10 2 0", ERR_CODE, DROP_CNT, OUT_VALID); end
        CLR_ERR = 1'b1;
        @(posedge CLK); #1 CLR_ERR = 1'b0;
        @(negedge CLK);
        checks++; if (ERR !== 1'b0 || ERR_CODE !== 2'b00 || DROP_CNT !== 8'd0) begin errors++;
            $display("FAIL clr_err: err=%b code=%b drop=%0d exp 0 00 0", ERR, ERR_CODE, DROP_CNT); end
    endtask

    task automatic test_back_to_back();
        bit ok1, ok2;
        logic [31:0] w [3] = '{32'h00100093, 32'h00200113, 32'h00300193};
        OUT_READY = 1'b0;
        push(7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd1, ok1);
        push(7'b0010011, 5'd2, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2, ok2);
        @(negedge CLK);
        IN_OPCODE = 7'b0010011; IN_RD = 5'd3; IN_RS1 = 5'd0; IN_FUNCT3 = 3'd0; IN_IMM = 32'd3;
        IN_VALID = 1'b1;
        checks++; if (!ok1 || !ok2 || IN_READY !== 1'b0) begin errors++;
            $display("FAIL full_ready: ok=%b%b in_ready=%b exp 11 0", ok1, ok2, IN_READY); end
        for (int c = 0; c < 3; c++) begin
            checks++; if (OUT_VALID !== 1'b1 || OUT_INSTR !== w[0] || OUT_ADDR !== exp_addr || IN_READY !== 1'b0) begin
                errors++;
                $display("FAIL stall_hold_%0d: valid=%b instr=%h addr=%h rdy=%b exp 1 %h %h 0",
                         c, OUT_VALID, OUT_INSTR, OUT_ADDR, IN_READY, w[0], exp_addr);
            end
            @(negedge CLK);
        end
        OUT_READY = 1'b1;
        @(negedge CLK);
        checks++; if (OUT_INSTR !== w[1] || OUT_ADDR !== exp_addr + 32'd4 || IN_READY !== 1'b1) begin errors++;
            $display("FAIL drain_1: instr=%h addr=%h rdy=%b exp %h %h 1", OUT_INSTR, OUT_ADDR, IN_READY,
                     w[1], exp_addr + 32'd4); end
        @(posedge CLK); #1 IN_VALID = 1'b0;
        @(negedge CLK);
        checks++; if (OUT_VALID !== 1'b1 || OUT_INSTR !== w[2] || OUT_ADDR !== exp_addr + 32'd8) begin errors++;
            $display("FAIL drain_2: valid=%b instr=%h addr=%h exp 1 %h %h", OUT_VALID, OUT_INSTR, OUT_ADDR,
                     w[2], exp_addr + 32'd8); end
        @(negedge CLK);
        checks++; if (OUT_VALID !== 1'b0) begin errors++;
            $display("FAIL drain_empty: valid=%b exp 0", OUT_VALID); end
        exp_addr = exp_addr + 32'd12;
    endtask

    task automatic test_err_precedence();
        bit ok;
        push(7'b1111111, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0, ok);
        @(negedge CLK);
        checks++; if (ERR !== 1'b1 || ERR_CODE !== 2'b01 || DROP_CNT !== 8'd1) begin errors++;
            $display("FAIL bad_opcode: err=%b code=%b drop=%0d exp 1 01 1", ERR, ERR_CODE, DROP_CNT); end
        push(7'b0010011, 5'd1, 5'd1, 5'd0, 3'd1, 7'd0, 32'd32, ok);
        @(negedge CLK);
        checks++; if (ERR_CODE !== 2'b01 || DROP_CNT !== 8'd2 || OUT_VALID !== 1'b0) begin errors++;
            $display("FAIL slli_range: code=%b drop=%0d valid=%b exp 01 2 0", ERR_CODE, DROP_CNT, OUT_VALID); end
        // Clear coincides with a new range error: the error wins.
        CLR_ERR = 1'b1;
        push(7'b0010011, 5'd1, 5'd1, 5'd0, 3'd1, 7'd0, 32'd32, ok);
        CLR_ERR = 1'b0;
        @(negedge CLK);
        checks++; if (ERR !== 1'b1 || ERR_CODE !== 2'b10 || DROP_CNT !== 8'd1) begin errors++;
            $display("FAIL clr_vs_err: err=%b code=%b drop=%0d exp 1 10 1", ERR, ERR_CODE, DROP_CNT); end
        CLR_ERR = 1'b1;
        @(posedge CLK); #1 CLR_ERR = 1'b0;
        push(7'b1101111, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h0010_0001, ok);
        @(negedge CLK);
        checks++; if (ERR_CODE !== 2'b11 || DROP_CNT !== 8'd1) begin errors++;
            $display("FAIL misal_over_range: code=%b drop=%0d exp 11 1", ERR_CODE, DROP_CNT); end
    endtask

    task automatic test_reset_midstream();
        bit ok;
        OUT_READY = 1'b0;
        push(7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd1, ok);
        push(7'b0010011, 5'd2, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2, ok);
        @(negedge CLK);
        checks++; if (OUT_VALID !== 1'b1 || ERR !== 1'b1) begin errors++;
            $display("FAIL pre_reset: valid=%b err=%b exp 1 1", OUT_VALID, ERR); end
        #2 NRST = 1'b0;
        #1;
        checks++; if (OUT_VALID !== 1'b0 || IN_READY !== 1'b0 || ERR !== 1'b0 || DROP_CNT !== 8'd0) begin
            errors++;
            $display("FAIL async_reset: valid=%b rdy=%b err=%b drop=%0d exp 0 0 0 0",
                     OUT_VALID, IN_READY, ERR, DROP_CNT);
        end
        @(negedge CLK); NRST = 1'b1; OUT_READY = 1'b1;
        push(7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5, ok);
        @(negedge CLK);
        checks++; if (!ok || OUT_INSTR !== 32'h00500093 || OUT_ADDR !== START || ERR !== 1'b0) begin errors++;
            $display("FAIL post_reset_word: ok=%b instr=%h addr=%h err=%b exp 1 00500093 %h 0",
                     ok, OUT_INSTR, OUT_ADDR, ERR, START); end
    endtask

    initial begin
        test_reset();
        test_first_word();
        test_encodings();
        test_errors();
        test_back_to_back();
        test_err_precedence();
        test_reset_midstream();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
